// File: rtl/t09_sound_sequencer.sv
// Sound-effect sequencer for the snake game: edge-detects collision and direction events,
// arbitrates them by priority with a one-entry pending slot, and holds each tone for a
// programmed number of millisecond ticks before handing the divider code downstream.
module t09_sound_sequencer #(
  parameter int unsigned TICK_DIV = 12000,
  parameter int unsigned DUR_MOVE = 20,
  parameter int unsigned DUR_GOOD = 80,
  parameter int unsigned DUR_BAD  = 150,
  parameter int unsigned DUR_GAP  = 50,
  parameter logic [7:0]  F_MOVE   = 8'd179,
  parameter logic [7:0]  F_GOOD   = 8'd107,
  parameter logic [7:0]  F_BAD    = 8'd151
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enable_i,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  input  logic [3:0] direction_i,
  output logic [7:0] freq,
  output logic       tone_en,
  output logic       busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DurMaxA = (DUR_MOVE > DUR_GOOD) ? DUR_MOVE : DUR_GOOD;
  localparam int unsigned DurMaxB = (DUR_BAD > DUR_GAP) ? DUR_BAD : DUR_GAP;
  localparam int unsigned DurMax  = (DurMaxA > DurMaxB) ? DurMaxA : DurMaxB;
  localparam int unsigned DW = (DurMax > 1) ? $clog2(DurMax) : 1;

  typedef enum logic [2:0] {StIdle, StMove, StGood, StBad1, StGap, StBad2} state_e;

  // Priority classes: 0 none, 1 move, 2 good, 3 bad.
  function automatic logic [1:0] state_prio(state_e s);
    unique case (s)
      StMove:                state_prio = 2'd1;
      StGood:                state_prio = 2'd2;
      StBad1, StGap, StBad2: state_prio = 2'd3;
      default:               state_prio = 2'd0;
    endcase
  endfunction

  function automatic state_e prio_state(logic [1:0] p);
    unique case (p)
      2'd1:    prio_state = StMove;
      2'd2:    prio_state = StGood;
      2'd3:    prio_state = StBad1;
      default: prio_state = StIdle;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    pend_q, pend_d;
  logic          bad_q, good_q;
  logic [3:0]    dir_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dur_q, dur_d, dur_last;
  logic [7:0]    freq_q, freq_d;
  logic          tone_q, tone_d, busy_q, busy_d;

  logic          ev_bad, ev_good, ev_move, done, entry;
  logic [1:0]    cand, second, cur, top;

  // Rising-edge / change detection against last cycle's inputs.
  always_comb begin
    ev_bad  = badColl_i & ~bad_q;
    ev_good = goodColl_i & ~good_q;
    ev_move = (direction_i != 4'd0) && (direction_i != dir_q);
    cand    = 2'd0;
    second  = 2'd0;
    if (ev_bad) begin
      cand   = 2'd3;
      second = ev_good ? 2'd2 : (ev_move ? 2'd1 : 2'd0);
    end else if (ev_good) begin
      cand   = 2'd2;
      second = ev_move ? 2'd1 : 2'd0;
    end else if (ev_move) begin
      cand   = 2'd1;
    end
  end

  // Last duration count of the current state.
  always_comb begin
    dur_last = '0;
    unique case (state_q)
      StMove:        dur_last = DW'(DUR_MOVE - 1);
      StGood:        dur_last = DW'(DUR_GOOD - 1);
      StBad1, StBad2: dur_last = DW'(DUR_BAD - 1);
      StGap:         dur_last = DW'(DUR_GAP - 1);
      default:       dur_last = '0;
    endcase
  end

  assign done = (state_q != StIdle) && (presc_q == PW'(TICK_DIV - 1)) && (dur_q == dur_last);

  // Next-state, pending-slot arbitration and duration counters.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    entry   = 1'b0;
    cur     = state_prio(state_q);
    top     = (pend_q > cand) ? pend_q : cand;
    if (!enable_i) begin
      state_d = StIdle;
      pend_d  = 2'd0;
      entry   = 1'b1;
    end else if (cand > cur) begin
      // Preempt (or start from idle); the interrupted sound is discarded.
      state_d = prio_state(cand);
      entry   = 1'b1;
      if (second > pend_q) pend_d = second;
    end else if (done && (state_q == StBad1 || state_q == StGap)) begin
      state_d = (state_q == StBad1) ? StGap : StBad2;
      entry   = 1'b1;
      if (cand > pend_q) pend_d = cand;
    end else if (done) begin
      // Completion: chain straight into the better of pending and the new event.
      state_d = prio_state(top);
      pend_d  = 2'd0;
      entry   = 1'b1;
    end else if (cand > pend_q) begin
      pend_d = cand;
    end

    presc_d = presc_q;
    dur_d   = dur_q;
    if (entry || state_q == StIdle) begin
      presc_d = '0;
      dur_d   = '0;
    end else if (presc_q == PW'(TICK_DIV - 1)) begin
      presc_d = '0;
      dur_d   = dur_q + DW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Registered outputs reflect the state being entered.
  always_comb begin
    freq_d = 8'd0;
    unique case (state_d)
      StMove:         freq_d = F_MOVE;
      StGood:         freq_d = F_GOOD;
      StBad1, StBad2: freq_d = F_BAD;
      default:        freq_d = 8'd0;
    endcase
    tone_d = (state_d == StMove) || (state_d == StGood) ||
             (state_d == StBad1) || (state_d == StBad2);
    busy_d = (state_d != StIdle);
  end

  // Input history updates every cycle, enabled or not.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bad_q  <= 1'b0;
      good_q <= 1'b0;
      dir_q  <= 4'd0;
    end else begin
      bad_q  <= badColl_i;
      good_q <= goodColl_i;
      dir_q  <= direction_i;
    end
  end

  // Sequencer state, pending slot and tick counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      pend_q  <= 2'd0;
      presc_q <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      presc_q <= presc_d;
      dur_q   <= dur_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      freq_q <= 8'd0;
      tone_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      freq_q <= freq_d;
      tone_q <= tone_d;
      busy_q <= busy_d;
    end
  end

  assign freq    = freq_q;
  assign tone_en = tone_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_t09_sound_sequencer.sv
// Scoreboard bench: a driver steps a behavioural model alongside the stimulus and queues the
// expected outputs; a monitor pops and compares after every active clock edge.
module tb_t09_sound_sequencer;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned DurMove = 2;
  localparam int unsigned DurGood = 3;
  localparam int unsigned DurBad  = 2;
  localparam int unsigned DurGap  = 1;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       enable_i = 1'b1;
  logic       goodColl_i = 1'b0;
  logic       badColl_i = 1'b0;
  logic [3:0] direction_i = 4'd0;
  logic [7:0] freq;
  logic       tone_en;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [9:0] exp_q[$];

  t09_sound_sequencer #(
    .TICK_DIV(TickDiv),
    .DUR_MOVE(DurMove),
    .DUR_GOOD(DurGood),
    .DUR_BAD (DurBad),
    .DUR_GAP (DurGap)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .enable_i   (enable_i),
    .goodColl_i (goodColl_i),
    .badColl_i  (badColl_i),
    .direction_i(direction_i),
    .freq       (freq),
    .tone_en    (tone_en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: current sound class, bad-sequence phase, cycles left in the segment.
  int         m_prio, m_phase, m_left, m_pend;
  logic       m_bad, m_good;
  logic [3:0] m_dir;

  function automatic int seg_len(int p, int ph);
    if (p == 1) return DurMove * TickDiv;
    if (p == 2) return DurGood * TickDiv;
    if (ph == 1) return DurGap * TickDiv;
    return DurBad * TickDiv;
  endfunction

  task automatic model_reset();
    m_prio = 0; m_phase = 0; m_left = 0; m_pend = 0;
    m_bad = 1'b0; m_good = 1'b0; m_dir = 4'd0;
  endtask

  task automatic model_start(int p);
    m_prio = p; m_phase = 0; m_left = seg_len(p, 0);
  endtask

  task automatic model_step(input logic en, input logic g, input logic b, input logic [3:0] d,
                            output logic [9:0] exp_o);
    int evs[$];
    int cand, second, top;
    logic [7:0] f;
    if (b && !m_bad) evs.push_back(3);
    if (g && !m_good) evs.push_back(2);
    if (d != 4'd0 && d != m_dir) evs.push_back(1);
    cand   = (evs.size() > 0) ? evs[0] : 0;
    second = (evs.size() > 1) ? evs[1] : 0;
    if (!en) begin
      m_prio = 0;
      m_pend = 0;
    end else if (cand > m_prio) begin
      model_start(cand);
      if (second > m_pend) m_pend = second;
    end else if (m_prio != 0 && m_left == 1) begin
      if (m_prio == 3 && m_phase < 2) begin
        m_phase = m_phase + 1;
        m_left  = seg_len(3, m_phase);
        if (cand > m_pend) m_pend = cand;
      end else begin
        top = (m_pend > cand) ? m_pend : cand;
        m_pend = 0;
        if (top > 0) model_start(top);
        else m_prio = 0;
      end
    end else begin
      if (m_prio != 0) m_left = m_left - 1;
      if (cand > m_pend) m_pend = cand;
    end
    m_bad = b; m_good = g; m_dir = d;
    case (m_prio)
      1: f = 8'd179;
      2: f = 8'd107;
      3: f = (m_phase == 1) ? 8'd0 : 8'd151;
      default: f = 8'd0;
    endcase
    exp_o = {f, (f != 8'd0), (m_prio != 0)};
  endtask

  // Drive one cycle of inputs (also releases reset) and queue the predicted response.
  task automatic drive(input logic en, input logic g, input logic b, input logic [3:0] d);
    logic [9:0] e;
    @(negedge clk);
    nrst = 1'b1;
    enable_i = en; goodColl_i = g; badColl_i = b; direction_i = d;
    model_step(en, g, b, d, e);
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) drive(enable_i, goodColl_i, badColl_i, direction_i);
  endtask

  task automatic check_idle_outputs(input string name);
    tests++;
    if (freq !== 8'd0 || tone_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s freq=%0d tone_en=%0b busy=%0b expected all zero", name, freq, tone_en,
               busy);
    end
  endtask

  // Monitor: every active edge after reset release presents one output word.
  always @(posedge clk) begin
    logic [9:0] e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({freq, tone_en, busy} !== e) begin
        fails++;
        $display("FAIL scoreboard cyc=%0d got freq=%0d tone_en=%0b busy=%0b expected freq=%0d tone_en=%0b busy=%0b",
                 cyc, freq, tone_en, busy, e[9:2], e[1], e[0]);
      end
    end
  end

  initial begin
    logic en, g, b;
    logic [3:0] d;
    int wait_cyc;
    model_reset();
    #2;
    check_idle_outputs("reset_initial");

    // Async reset in the middle of BAD1.
    drive(1, 0, 0, 4'd0);
    drive(1, 0, 1, 4'd0);
    drive(1, 0, 0, 4'd0);
    hold(3);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1 check_idle_outputs("reset_mid_bad1");
    model_reset();

    // Good level held: one sound from the edge, no retrigger.
    drive(1, 0, 0, 4'd0);
    drive(1, 1, 0, 4'd0);
    hold(20);
    drive(1, 0, 0, 4'd0);

    // Move: hold, then change direction.
    hold(2);
    drive(1, 0, 0, 4'b0010);
    hold(12);
    drive(1, 0, 0, 4'b1000);
    hold(10);
    drive(1, 0, 0, 4'd0);
    hold(3);

    // Bad sequence alone.
    drive(1, 0, 1, 4'd0);
    drive(1, 0, 0, 4'd0);
    hold(24);

    // Good preempts move.
    drive(1, 0, 0, 4'b0001);
    hold(2);
    drive(1, 1, 0, 4'b0001);
    drive(1, 0, 0, 4'b0001);
    hold(16);
    drive(1, 0, 0, 4'd0);

    // Move and good pended during BAD1; good follows BAD2 directly.
    drive(1, 0, 1, 4'd0);
    drive(1, 0, 0, 4'd0);
    drive(1, 0, 0, 4'b0100);
    drive(1, 1, 0, 4'b0100);
    drive(1, 0, 0, 4'b0100);
    hold(36);

    // Bad and good together, then disable mid-GOOD.
    drive(1, 1, 1, 4'd0);
    drive(1, 0, 0, 4'd0);
    hold(24);
    drive(0, 0, 0, 4'd0);
    hold(3);
    drive(1, 0, 0, 4'd0);
    hold(15);

    // Randomized traffic.
    en = 1'b1; g = 1'b0; b = 1'b0; d = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      if (en ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) == 0)) en = ~en;
      if ($urandom_range(0, 11) == 0) g = ~g;
      if ($urandom_range(0, 15) == 0) b = ~b;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 4))
          0: d = 4'd0;
          1: d = 4'b0001;
          2: d = 4'b0010;
          3: d = 4'b0100;
          default: d = 4'b1000;
        endcase
      end
      drive(en, g, b, d);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      #2;
      wait_cyc++;
    end
    tests++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain queue_left=%0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
